// File: rtl/tcore_param.sv
// Shared core parameters and the fetch-queue entry type.
package tcore_param;

    localparam int unsigned TCORE_XLEN              = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT        = 4;
    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;
    localparam logic [31:0] RESET_VECTOR_DEFAULT    = 32'h4000_0000;

    // One decoded-side fetch-queue entry; pc is held at core width.
    typedef struct packed {
        logic [TCORE_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  err;
    } fq_entry_t;

endpackage

// File: rtl/stage1_prefetch_if.sv
// Memory-request, response, redirect and decode-side signals of the prefetch stage.
interface stage1_prefetch_if
    import tcore_param::*;
#(
    parameter int unsigned XLEN = TCORE_XLEN
);
    logic            flush_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            req_valid_o;
    logic            req_ready_i;
    logic [XLEN-1:0] req_addr_o;
    logic            rsp_valid_i;
    logic [31:0]     rsp_data_i;
    logic            rsp_err_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    logic [31:0]     out_instr_o;
    logic            out_err_o;

    // Prefetch stage side.
    modport master (
        input  flush_i, redirect_pc_i, req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i,
               out_ready_i,
        output req_valid_o, req_addr_o, out_valid_o, out_pc_o, out_instr_o, out_err_o
    );

    // Memory / decode / redirect side.
    modport slave (
        output flush_i, redirect_pc_i, req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i,
               out_ready_i,
        input  req_valid_o, req_addr_o, out_valid_o, out_pc_o, out_instr_o, out_err_o
    );

endinterface

// File: rtl/fq_fifo.sv
// Generic synchronous FIFO with flush; push while full is accepted when a pop happens too.
module fq_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and count update; flush wins over push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CntW'(1);
            else if (!do_push && do_pop) count_d = count_q - CntW'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/stage1_prefetch.sv
// Instruction prefetch: issues word fetches under a credit limit, tags them with their PC,
// queues responses for decode, and discards in-flight responses across a redirect.
module stage1_prefetch
    import tcore_param::*;
#(
    parameter int unsigned     XLEN            = TCORE_XLEN,
    parameter int unsigned     FQ_DEPTH        = FQ_DEPTH_DEFAULT,
    parameter int unsigned     MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic                clk_i,
    input  logic                rst_ni,  // active-high asynchronous reset
    stage1_prefetch_if.master   bus
);
    localparam int unsigned OccW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SumW = OccW + 1;  // MAX_OUTSTANDING <= FQ_DEPTH

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            started_q;
    logic            halted_q, halted_d;
    logic [OutW-1:0] drop_cnt_q, drop_cnt_d;

    fq_entry_t       q_head, q_wdata;
    logic            q_push, q_pop, q_full, q_empty;
    logic [OccW-1:0] q_count;
    logic [XLEN-1:0] tag_pc;
    logic            tag_push, tag_pop, tag_full, tag_empty;
    logic [OutW-1:0] tag_count;

    logic [SumW-1:0] in_flight;
    logic            req_valid, req_hs, rsp_any, rsp_drop, rsp_take;

    // Dropped responses still occupy memory-side slots, so they count toward the limit.
    assign in_flight = SumW'(tag_count) + SumW'(drop_cnt_q);
    assign req_valid = started_q & ~halted_q & ~bus.flush_i & ~tag_full & ~q_full
                     & (in_flight < SumW'(MAX_OUTSTANDING))
                     & ((SumW'(q_count) + SumW'(tag_count)) < SumW'(FQ_DEPTH));
    assign req_hs    = req_valid & bus.req_ready_i;

    assign rsp_any  = bus.rsp_valid_i & (in_flight != '0);
    assign rsp_drop = bus.rsp_valid_i & (drop_cnt_q != '0);
    assign rsp_take = bus.rsp_valid_i & (drop_cnt_q == '0) & ~tag_empty & ~bus.flush_i;

    assign tag_push = req_hs;
    assign tag_pop  = rsp_take;
    assign q_push   = rsp_take;
    assign q_pop    = ~q_empty & bus.out_ready_i;
    assign q_wdata  = '{pc: TCORE_XLEN'(tag_pc), instr: bus.rsp_data_i, err: bus.rsp_err_i};

    assign bus.req_valid_o = req_valid;
    assign bus.req_addr_o  = {fetch_pc_q[XLEN-1:2], 2'b00};
    assign bus.out_valid_o = ~q_empty;
    assign bus.out_pc_o    = XLEN'(q_head.pc);
    assign bus.out_instr_o = q_head.instr;
    assign bus.out_err_o   = q_head.err;

    fq_fifo #(
        .Width ($bits(fq_entry_t)),
        .Depth (FQ_DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (bus.flush_i),
        .push_i  (q_push),
        .data_i  (q_wdata),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    fq_fifo #(
        .Width (XLEN),
        .Depth (MAX_OUTSTANDING)
    ) u_tags (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (bus.flush_i),
        .push_i  (tag_push),
        .data_i  (bus.req_addr_o),
        .pop_i   (tag_pop),
        .data_o  (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    // Next fetch PC, halt flag and drop counter.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.flush_i) begin
            fetch_pc_d = bus.redirect_pc_i;
            halted_d   = 1'b0;
            drop_cnt_d = OutW'(in_flight - SumW'(rsp_any));
        end else begin
            if (req_hs)                fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_drop)              drop_cnt_d = drop_cnt_q - OutW'(1);
            if (q_push && q_wdata.err) halted_d   = 1'b1;
        end
    end

    // Stage state register.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            fetch_pc_q <= RESET_VECTOR;
            started_q  <= 1'b0;
            halted_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            started_q  <= 1'b1;
            halted_q   <= halted_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_stage1_prefetch.sv
// Randomized bench for stage1_prefetch against a transaction-level reference model.
module tb_stage1_prefetch;
    localparam int unsigned FQ   = 4;
    localparam int unsigned MAXO = 2;
    localparam logic [31:0] RV   = 32'h4000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage1_prefetch_if #(.XLEN(32)) bus ();

    stage1_prefetch #(
        .XLEN            (32),
        .FQ_DEPTH        (FQ),
        .MAX_OUTSTANDING (MAXO),
        .RESET_VECTOR    (RV)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: requests in flight (stale after a redirect) and queued entries.
    typedef struct { logic [31:0] pc; bit stale; } inf_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;
    inf_t        inflight[$];
    ent_t        entries[$];
    logic [31:0] m_fetch_pc;
    bit          m_started, m_halted;
    logic [31:0] mem_q[$];  // memory side: addresses accepted but not yet answered

    function automatic void model_reset();
        inflight.delete();
        entries.delete();
        m_fetch_pc = RV;
        m_started  = 1'b0;
        m_halted   = 1'b0;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (inflight[i]) if (!inflight[i].stale) n++;
        return n;
    endfunction

    function automatic bit exp_req_valid();
        return m_started && !m_halted && !bus.flush_i && (inflight.size() < int'(MAXO))
            && (entries.size() + live_cnt() < int'(FQ));
    endfunction

    task automatic drive(input int mode);
        int sel;
        bus.rsp_data_i    = $urandom;
        bus.rsp_err_i     = 1'b0;
        bus.flush_i       = 1'b0;
        bus.redirect_pc_i = $urandom;
        bus.req_ready_i   = 1'b1;
        bus.rsp_valid_i   = (mem_q.size() > 0);
        bus.out_ready_i   = (mode != 1);
        if (mode == 2) begin
            bus.flush_i     = ($urandom % 24 == 0);
            sel             = $urandom % 4;
            if (sel == 0) bus.redirect_pc_i = 32'h8000_0002;
            if (sel == 1) bus.redirect_pc_i = 32'hFFFF_FFFC;
            bus.req_ready_i = ($urandom % 4 != 0);
            bus.rsp_valid_i = (mem_q.size() > 0) ? ($urandom % 3 != 0) : ($urandom % 8 == 0);
            bus.rsp_err_i   = ($urandom % 24 == 0);
            bus.out_ready_i = ($urandom % 3 != 0);
        end
    endtask

    task automatic step(input int mode);
        bit   ev, pop;
        inf_t r;
        ent_t e;
        drive(mode);
        @(negedge clk);
        ev = exp_req_valid();
        check_eq("req_valid", 32'(bus.req_valid_o), 32'(ev));
        check_eq("req_addr", bus.req_addr_o, {m_fetch_pc[31:2], 2'b00});
        check_eq("out_valid", 32'(bus.out_valid_o), 32'(entries.size() > 0));
        if (entries.size() > 0) begin
            check_eq("out_pc", bus.out_pc_o, entries[0].pc);
            check_eq("out_instr", bus.out_instr_o, entries[0].instr);
            check_eq("out_err", 32'(bus.out_err_o), 32'(entries[0].err));
        end
        @(posedge clk);
        pop = (entries.size() > 0) && bus.out_ready_i;
        if (bus.flush_i) begin
            entries.delete();
            if (bus.rsp_valid_i && inflight.size() > 0) r = inflight.pop_front();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch_pc = bus.redirect_pc_i;
            m_halted   = 1'b0;
        end else begin
            if (pop) e = entries.pop_front();
            if (bus.rsp_valid_i && inflight.size() > 0) begin
                r = inflight.pop_front();
                if (!r.stale) begin
                    entries.push_back('{pc: r.pc, instr: bus.rsp_data_i, err: bus.rsp_err_i});
                    if (bus.rsp_err_i) m_halted = 1'b1;
                end
            end
            if (ev && bus.req_ready_i) begin
                inflight.push_back('{pc: {m_fetch_pc[31:2], 2'b00}, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        m_started = 1'b1;
        if (bus.rsp_valid_i && mem_q.size() > 0) void'(mem_q.pop_front());
        if (ev && bus.req_ready_i) mem_q.push_back({m_fetch_pc[31:2], 2'b00} - 32'd4);
        #1;
    endtask

    initial begin
        bus.flush_i       = 1'b0;
        bus.redirect_pc_i = '0;
        bus.req_ready_i   = 1'b0;
        bus.rsp_valid_i   = 1'b0;
        bus.rsp_data_i    = '0;
        bus.rsp_err_i     = 1'b0;
        bus.out_ready_i   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("rst_req_addr", bus.req_addr_o, RV);
        rst = 1'b0;

        repeat (30)  step(0);  // streaming, memory answers next cycle
        repeat (30)  step(1);  // decode stalled: queue fills, requests stop
        repeat (900) step(2);  // random traffic, redirects, faults

        // Asynchronous reset mid-operation.
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_req_valid", 32'(bus.req_valid_o), 32'd0);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("mid_rst_req_addr", bus.req_addr_o, RV);
        model_reset();
        mem_q.delete();
        bus.rsp_valid_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (10)  step(0);
        repeat (900) step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stage1_prefetch.md
STAGE1_PREFETCH -- requirements
Module: stage1_prefetch

Interface
REQ-001 Parameter XLEN, default 32: address/PC width.
REQ-002 Parameter FQ_DEPTH, default 4: fetch-queue entries; power of two, >=2.
REQ-003 Parameter MAX_OUTSTANDING, default 2: in-flight memory requests; 1..FQ_DEPTH.
REQ-004 Parameter RESET_VECTOR, default 32'h4000_0000: first fetch address.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-high (asserted = 1).
REQ-007 flush_i  in  1  redirect; discards queue and in-flight responses.
REQ-008 redirect_pc_i  in  XLEN  new fetch address, sampled when flush_i=1.
REQ-009 req_valid_o  out  1  memory fetch request valid.
REQ-010 req_ready_i  in  1  memory accepts request.
REQ-011 req_addr_o  out  XLEN  word-aligned fetch address.
REQ-012 rsp_valid_i  in  1  in-order response valid, one per accepted request.
REQ-013 rsp_data_i  in  32  instruction word.
REQ-014 rsp_err_i  in  1  access fault for this response.
REQ-015 out_valid_o  out  1  queue head valid to decode.
REQ-016 out_ready_i  in  1  decode accepts head.
REQ-017 out_pc_o  out  XLEN  PC of head entry.
REQ-018 out_instr_o  out  32  instruction of head entry.
REQ-019 out_err_o  out  1  fault flag of head entry.

Function
REQ-020 Request handshake = req_valid_o & req_ready_i; on handshake fetch_pc advances by 4 (modulo 2^XLEN, wrap allowed).
REQ-021 req_valid_o = started & !halted & !flush_i & (outstanding < MAX_OUTSTANDING) & (occupancy + outstanding < FQ_DEPTH).
REQ-022 req_addr_o = fetch_pc with bits [1:0] forced to 0.
REQ-023 Each accepted request pushes its address into a PC-tag FIFO of depth MAX_OUTSTANDING; responses pop it in order.
REQ-024 Non-discarded response writes {tag PC, rsp_data_i, rsp_err_i} into queue; out_valid_o asserts the following cycle (1-cycle latency, no bypass).
REQ-025 out_valid_o = queue not empty; pop on out_valid_o & out_ready_i; head outputs stable while out_valid_o & !out_ready_i.
REQ-026 Simultaneous push and pop at any occupancy, including full, SHALL be legal; REQ-021 credit rule guarantees no overflow.
REQ-027 flush_i=1: queue emptied, tag FIFO cleared, fetch_pc <= redirect_pc_i, halted cleared, drop_cnt <= outstanding minus any response arriving that cycle.
REQ-028 Responses arriving while drop_cnt>0 are discarded and decrement drop_cnt; a response in the flush cycle itself is discarded.
REQ-029 New requests after flush count toward MAX_OUTSTANDING together with drop_cnt.
REQ-030 Enqueuing an entry with err=1 sets halted; no further requests until flush_i.
REQ-031 rsp_valid_i with no outstanding or dropped request is ignored, state unchanged.
REQ-032 Counters (occupancy, outstanding, drop_cnt) are $clog2(N+1) bits wide, never wrap.

Reset
REQ-033 While reset asserted: fetch_pc=RESET_VECTOR, queue/tag FIFO empty, counters 0, halted=0, started=0, out_valid_o=0, req_valid_o=0, req_addr_o=RESET_VECTOR.
REQ-034 started sets on first clock edge after reset deassertion; first request may issue in that following cycle.
REQ-035 Reset asserted mid-operation SHALL immediately (asynchronously) return all state to REQ-033 values; later responses are ignored per REQ-031.

Structure
REQ-036 Entry typedef fq_entry_t {pc, instr, err} and defaults FQ_DEPTH, MAX_OUTSTANDING belong in tcore_param.
REQ-037 One generic sub-module fq_fifo (parametrised width/depth, push/pop/flush, full/empty/count) used for both queue and tag FIFO.
REQ-038 Block replaces fetch-side PC/queue logic only; compressed expansion and prediction remain downstream.

Verification
REQ-039 Reset release, req_ready_i=1, 1-cycle response -> requests at 4000_0000, 4000_0004, ...; first out_valid_o 2 cycles after first handshake.
REQ-040 out_ready_i=0, memory always ready -> exactly FQ_DEPTH entries queued, req_valid_o low; one pop -> one new request.
REQ-041 Two requests in flight, flush_i with redirect_pc_i=8000_0002 -> both old responses dropped, next req_addr_o=8000_0000, out_pc_o=8000_0000.
REQ-042 Flush coincident with rsp_valid_i and out_ready_i -> response discarded, queue empty next cycle, drop_cnt=outstanding-1.
REQ-043 rsp_err_i=1 on 2nd response -> entry out_err_o=1, req_valid_o stays 0 until flush.
REQ-044 fetch_pc=FFFF_FFFC -> next request address 0000_0000.
